seq_alu_responder: RTL and testbench
====================================

Name: seq_alu_responder

Overview:
- Synthesizable responder for the stimulus controller's 8-bit operand/mode interface.
- Accepts one operation per valid/ready handshake and computes it.
- Returns the result on a separate valid/ready output channel.
- Add/sub/shift complete in one cycle; multiply and divide/modulo run as 8-step iterative engines so the emulator exercises real multi-cycle timing.

Parameters:
- WIDTH, 8, operand and result width in bits
- MODE_W, 8, mode field width
- ITER, WIDTH, iterations for multiply/divide engines; fixed equal to WIDTH

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/mode presented
- in_ready  output  1  responder can accept an operation
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- mode_in  input  MODE_W  operation select
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- c_out  output  WIDTH  result
- flags  output  3  {bad_mode, div_zero, overflow}, valid with out_valid

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; c_out=0; flags=0; engine registers cleared.
- Accept on clk edge with in_valid&&in_ready: latch a, b, mode; in_ready drops next cycle.
- Modes, all arithmetic mod 2^WIDTH:
  - 0: a+b; overflow=carry out.
  - 1: a-b; overflow=borrow.
  - 2: b-a; overflow=borrow.
  - 3: a*b low byte; overflow=high byte nonzero.
  - 4: a>>b.
  - 5: a<<b.
  - 6: b>>a.
  - 7: b<<a.
  - 8: a/b.
  - 9: a%b.
  - >=10: c=0, bad_mode=1, single-cycle.
- Shift amounts >=WIDTH yield 0, no flag.
- States: IDLE -> (accept) EXEC -> RESP -> IDLE.
  - EXEC is 1 cycle for single-cycle modes.
  - EXEC is ITER cycles for modes 3/8/9.
  - Multiply: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- Latency from accept edge to out_valid high: 2 cycles for single-cycle modes; ITER+1 cycles for 3/8/9.
- RESP: out_valid=1; c_out and flags held stable until out_valid&&out_ready. Then next cycle out_valid=0, in_ready=1, state IDLE.
- Back-to-back: in_ready goes high in the cycle after the response handshake; no accept while out_valid=1.
- in_valid while busy is ignored; the master must hold its data, per valid/ready rules.
- Divide by zero (b=0, mode 8 or 9): skip iteration and go to RESP after 1 EXEC cycle. Mode 8 gives c=all-ones; mode 9 gives c=a. div_zero=1 in both cases.
- rst_n low mid-operation: abort immediately; all outputs return to reset values within the same cycle (async). No stale result after release.
- out_ready high while out_valid=0 has no effect.

Decomposition:
- Shared package seq_alu_pkg holds:
  - mode_e enum (MODE_ADD=0 .. MODE_MOD=9)
  - state_e enum (IDLE, EXEC, RESP)
  - flag bit-index constants
  - WIDTH default
  The stimulus controller imports the same package.
- One natural sub-module: seq_alu_iter_engine. It implements the shared shift-add multiply / restoring divide datapath with start/done, op select, a, b, and product/quotient/remainder outputs.
- The top level owns the handshake FSM, single-cycle ops and flag muxing.

Test Plan:
- Add: a=12, b=34, mode=0, out_ready=1 -> out_valid 2 cycles after accept; c=46; flags=0.
- Multiply with overflow: a=3, b=7, mode=3 -> c=21 at ITER+1 cycles, in_ready low throughout. Then a=20, b=20 -> c=144, overflow=1.
- Divide/modulo: a=56, b=9, mode=8 -> c=6. Mode=9 -> c=2. b=0, mode=8 -> c=255, div_zero=1.
- Shifts and bad mode: a=9, b=1, mode=4 -> 4. Mode=5 -> 18. a=2, b=32, mode=6 -> 8. a=3, b=8, mode=5 -> 0. Mode=12 -> c=0, bad_mode=1.
- Backpressure: a=45, b=10, mode=1 with out_ready=0 for 5 cycles -> c=35, out_valid held, c_out stable, in_ready=0. Handshake when out_ready rises, then in_ready=1 next cycle.
- Reset mid-multiply: assert rst_n low at EXEC cycle 4 -> out_valid=0, in_ready=1, c_out=0 immediately. After release, a new add 1+1 -> c=2 with no residue.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU responder and its stimulus controller.
//   - default operand/result width and mode field width
//   - mode_e: operation encodings carried on mode_in
//   - state_e: handshake FSM states
//   - flag bit positions within the 3-bit flags bus {bad_mode, div_zero, overflow}
//   - needs_engine(): whether an operation runs on the iterative engine
package seq_alu_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int MODE_W_DEF = 8;

    localparam int FLAG_OVF = 0;
    localparam int FLAG_DZ  = 1;
    localparam int FLAG_BAD = 2;

    typedef enum logic [MODE_W_DEF-1:0] {
        MODE_ADD  = 8'd0,
        MODE_SUB  = 8'd1,
        MODE_RSUB = 8'd2,
        MODE_MUL  = 8'd3,
        MODE_SHR  = 8'd4,
        MODE_SHL  = 8'd5,
        MODE_RSHR = 8'd6,
        MODE_RSHL = 8'd7,
        MODE_DIV  = 8'd8,
        MODE_MOD  = 8'd9
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Multiply always iterates; divide/modulo iterate only for a nonzero
    // divisor (divide-by-zero is resolved in a single cycle).
    function automatic logic needs_engine(input logic [MODE_W_DEF-1:0] mode,
                                          input logic                  b_is_zero);
        return (mode == MODE_MUL) ||
               (((mode == MODE_DIV) || (mode == MODE_MOD)) && !b_is_zero);
    endfunction

endpackage

// File: rtl/seq_alu_iter_engine.sv
// Iterative multiply / divide datapath shared by MUL, DIV and MOD.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load operands and begin W iteration steps
//   op_div      : 0 = shift-add multiply (LSB first), 1 = restoring divide (MSB first)
//   a, b        : operands (multiply a*b, divide a/b)
//   done        : high during the final step; outputs are valid in that cycle
//   product     : full 2*W-bit product
//   quotient    : a / b
//   remainder   : a % b
// Outputs are the register next-state values, so the caller captures the
// result on the same edge that performs the last step.
module seq_alu_iter_engine
    import seq_alu_pkg::*;
#(
    parameter int W = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           op_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    localparam int CNT_W = $clog2(W + 1);

    // acc holds {high half, low half}:
    //   multiply: {partial product, remaining multiplier bits}
    //   divide  : {partial remainder, dividend bits shifting into quotient}
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;   // multiplicand or divisor
    logic [CNT_W-1:0] cnt_q, cnt_d;     // steps remaining; zero when idle
    logic             op_div_q, op_div_d;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;

    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        mul_sum   = '0;
        div_shift = '0;
        if (start) begin
            op_div_d = op_div;
            opnd_d   = op_div ? b : a;
            acc_d    = {{W{1'b0}}, (op_div ? a : b)};
            cnt_d    = CNT_W'(W);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (op_div_q) begin
                // Bring the next dividend bit into the partial remainder and
                // subtract the divisor if it fits; the quotient bit fills the
                // vacated LSB.
                div_shift = acc_q[2*W-1:W-1];
                if (div_shift >= {1'b0, opnd_q}) begin
                    acc_d = {div_shift[W-1:0] - opnd_q, acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
                end
            end else begin
                // Add the multiplicand when the current multiplier bit is set,
                // then shift the whole accumulator right, carry included.
                mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
                acc_d   = {mul_sum, acc_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
        end
    end

    assign done      = (cnt_q == CNT_W'(1));
    assign product   = acc_d;
    assign quotient  = acc_d[W-1:0];
    assign remainder = acc_d[2*W-1:W];

endmodule

// File: rtl/seq_alu_responder.sv
// Sequential ALU responder: accepts one operation per in_valid/in_ready
// handshake, computes it, and returns the result on out_valid/out_ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (in_ready high only in IDLE)
//   a_in, b_in, mode_in : operands and operation select
//   out_valid/out_ready : result handshake (out_valid high only in RESP)
//   c_out               : result, held stable while out_valid
//   flags               : {bad_mode, div_zero, overflow}, valid with out_valid
// Single-cycle ops spend one cycle in EXEC; MUL and nonzero-divisor DIV/MOD
// spend WIDTH cycles in EXEC on the iterative engine.
module seq_alu_responder
    import seq_alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int MODE_W = MODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [MODE_W-1:0] mode_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  c_out,
    output logic [2:0]        flags
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [WIDTH-1:0]    c_q, c_d;
    logic [2:0]          flags_q, flags_d;

    logic                accept;
    logic                eng_start;
    logic                eng_done;
    logic [2*WIDTH-1:0]  eng_product;
    logic [WIDTH-1:0]    eng_quotient;
    logic [WIDTH-1:0]    eng_remainder;
    logic [WIDTH-1:0]    eng_c;
    logic [2:0]          eng_flags;
    logic [WIDTH-1:0]    sc_c;
    logic [2:0]          sc_flags;
    logic [WIDTH:0]      wide;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign c_out     = c_q;
    assign flags     = flags_q;
    assign accept    = in_valid && in_ready;

    // The engine loads straight from the input bus on the accept edge so
    // that EXEC spends exactly WIDTH cycles iterating.
    assign eng_start = accept && needs_engine(mode_in, (b_in == '0));

    seq_alu_iter_engine #(
        .W (WIDTH)
    ) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (eng_start),
        .op_div    (mode_in != MODE_MUL),
        .a         (a_in),
        .b         (b_in),
        .done      (eng_done),
        .product   (eng_product),
        .quotient  (eng_quotient),
        .remainder (eng_remainder)
    );

    // Result selection for iterative operations.
    always_comb begin
        eng_c     = eng_quotient;
        eng_flags = '0;
        if (mode_q == MODE_MUL) begin
            eng_c               = eng_product[WIDTH-1:0];
            eng_flags[FLAG_OVF] = |eng_product[2*WIDTH-1:WIDTH];
        end else if (mode_q == MODE_MOD) begin
            eng_c = eng_remainder;
        end
    end

    // Single-cycle operations. Logical shifts by WIDTH or more already give
    // zero, which is the required result, so no clamp is needed.
    always_comb begin
        sc_c     = '0;
        sc_flags = '0;
        wide     = '0;
        case (mode_q)
            MODE_ADD: begin
                wide               = {1'b0, a_q} + {1'b0, b_q};
                sc_c               = wide[WIDTH-1:0];
                sc_flags[FLAG_OVF] = wide[WIDTH];
            end
            MODE_SUB: begin
                wide               = {1'b0, a_q} - {1'b0, b_q};
                sc_c               = wide[WIDTH-1:0];
                sc_flags[FLAG_OVF] = wide[WIDTH];
            end
            MODE_RSUB: begin
                wide               = {1'b0, b_q} - {1'b0, a_q};
                sc_c               = wide[WIDTH-1:0];
                sc_flags[FLAG_OVF] = wide[WIDTH];
            end
            MODE_SHR:  sc_c = a_q >> b_q;
            MODE_SHL:  sc_c = a_q << b_q;
            MODE_RSHR: sc_c = b_q >> a_q;
            MODE_RSHL: sc_c = b_q << a_q;
            MODE_MUL:  sc_c = '0;
            // DIV/MOD only land here with a zero divisor.
            MODE_DIV: begin
                sc_c              = '1;
                sc_flags[FLAG_DZ] = 1'b1;
            end
            MODE_MOD: begin
                sc_c              = a_q;
                sc_flags[FLAG_DZ] = 1'b1;
            end
            default:   sc_flags[FLAG_BAD] = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        c_d     = c_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    mode_d  = mode_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!needs_engine(mode_q, (b_q == '0))) begin
                    c_d     = sc_c;
                    flags_d = sc_flags;
                    state_d = RESP;
                end else if (eng_done) begin
                    c_d     = eng_c;
                    flags_d = eng_flags;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_seq_alu_responder.sv
// Self-checking bench for seq_alu_responder: directed cases followed by
// randomized operations. A driver pushes expected results into a scoreboard
// queue on each accept; an independent monitor compares whenever the DUT
// presents out_valid.
module tb_seq_alu_responder;
    import seq_alu_pkg::*;

    localparam int ITER = WIDTH_DEF;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a_in      = '0;
    logic [7:0] b_in      = '0;
    logic [7:0] mode_in   = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] c_out;
    logic [2:0] flags;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;
    bit          rand_ready = 1'b0;

    typedef struct {
        logic [7:0]  c;
        logic [2:0]  f;
        int          lat;
        int unsigned acc_cyc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  m;
    } exp_t;

    exp_t sb[$];

    seq_alu_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        exp_t e;
        int ai = int'(a);
        int bi = int'(b);
        int r;
        e.a = a; e.b = b; e.m = m;
        e.c = '0; e.f = '0; e.lat = 2; e.acc_cyc = 0;
        case (int'(m))
            0: begin r = ai + bi; e.c = 8'(r); e.f[0] = (r > 255); end
            1: begin r = ai - bi; e.c = 8'(r); e.f[0] = (ai < bi); end
            2: begin r = bi - ai; e.c = 8'(r); e.f[0] = (bi < ai); end
            3: begin r = ai * bi; e.c = 8'(r); e.f[0] = (r > 255); e.lat = ITER + 1; end
            4: e.c = (bi >= 8) ? 8'd0 : 8'((ai >> bi) % 256);
            5: e.c = (bi >= 8) ? 8'd0 : 8'((ai << bi) % 256);
            6: e.c = (ai >= 8) ? 8'd0 : 8'((bi >> ai) % 256);
            7: e.c = (ai >= 8) ? 8'd0 : 8'((bi << ai) % 256);
            8: begin
                if (bi == 0) begin e.c = 8'd255; e.f[1] = 1'b1; end
                else begin e.c = 8'(ai / bi); e.lat = ITER + 1; end
            end
            9: begin
                if (bi == 0) begin e.c = a; e.f[1] = 1'b1; end
                else begin e.c = 8'(ai % bi); e.lat = ITER + 1; end
            end
            default: begin e.c = 8'd0; e.f[2] = 1'b1; end
        endcase
        return e;
    endfunction

    // Issue one operation, push its expectation, then wait until the result
    // appears while confirming the responder refuses new work meanwhile.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        int   wait_cnt = 0;
        bit   busy_ok  = 1'b1;
        exp_t e;
        @(negedge clk);
        a_in = a; b_in = b; mode_in = m; in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            wait_cnt++;
            if (wait_cnt > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, wait_cnt);
                in_valid = 1'b0;
                return;
            end
        end
        e = model(a, b, m);
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); mode_in = 8'($urandom);
        wait_cnt = 0;
        while (!out_valid) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            wait_cnt++;
            if (wait_cnt > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL result_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, wait_cnt);
                return;
            end
        end
        n_cmp++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL busy_ready: in_ready rose while busy (a=%0d b=%0d mode=%0d), required 0", a, b, m);
        end
    endtask

    task automatic drain();
        int wait_cnt = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            wait_cnt++;
            if (wait_cnt > 300) begin
                n_cmp++; n_fail++;
                $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
                sb.delete();
                return;
            end
        end
        @(negedge clk);
    endtask

    // Random output backpressure during the randomized phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard checker.
    initial begin
        bit   seen    = 1'b0;
        bit   post_hs = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                seen = 1'b0; post_hs = 1'b0;
                continue;
            end
            if (post_hs) begin
                post_hs = 1'b0;
                n_cmp++;
                if (!(in_ready && !out_valid)) begin
                    n_fail++;
                    $display("FAIL post_handshake: in_ready=%0b out_valid=%0b, required in_ready=1 out_valid=0", in_ready, out_valid);
                end
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_out: out_valid=1 c_out=%0d with no operation outstanding", c_out);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1'b1;
                        n_cmp++;
                        if (int'(cyc - e.acc_cyc) != e.lat) begin
                            n_fail++;
                            $display("FAIL latency: a=%0d b=%0d mode=%0d took %0d cycles, required %0d", e.a, e.b, e.m, int'(cyc - e.acc_cyc), e.lat);
                        end
                    end
                    n_cmp++;
                    if (c_out !== e.c || flags !== e.f || in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL result: a=%0d b=%0d mode=%0d got c=%0d flags=%b in_ready=%0b, required c=%0d flags=%b in_ready=0", e.a, e.b, e.m, c_out, flags, in_ready, e.c, e.f);
                    end
                    if (out_ready) begin
                        $display("txn a=%0d b=%0d mode=%0d -> c=%0d flags=%b", e.a, e.b, e.m, c_out, flags);
                        void'(sb.pop_front());
                        seen    = 1'b0;
                        post_hs = 1'b1;
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c_out !== 8'd0 || flags !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b c_out=%0d flags=%b, required 1 0 0 000", in_ready, out_valid, c_out, flags);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        issue(8'd12, 8'd34, MODE_ADD);
        issue(8'd3,  8'd7,  MODE_MUL);
        issue(8'd20, 8'd20, MODE_MUL);
        issue(8'd56, 8'd9,  MODE_DIV);
        issue(8'd56, 8'd9,  MODE_MOD);
        issue(8'd56, 8'd0,  MODE_DIV);
        issue(8'd56, 8'd0,  MODE_MOD);
        issue(8'd9,  8'd1,  MODE_SHR);
        issue(8'd9,  8'd1,  MODE_SHL);
        issue(8'd2,  8'd32, MODE_RSHR);
        issue(8'd3,  8'd8,  MODE_SHL);
        issue(8'd3,  8'd5,  MODE_RSHL);
        issue(8'd5,  8'd9,  MODE_RSUB);
        issue(8'd200, 8'd100, MODE_ADD);
        issue(8'd3,  8'd8,  8'd12);
        drain();

        // Backpressure: result must hold while out_ready stays low.
        out_ready = 1'b0;
        issue(8'd45, 8'd10, MODE_SUB);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a multiply.
        @(negedge clk);
        a_in = 8'd200; b_in = 8'd150; mode_in = MODE_MUL; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || c_out !== 8'd0 || flags !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: out_valid=%0b in_ready=%0b c_out=%0d flags=%b, required 0 1 0 000", out_valid, in_ready, c_out, flags);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8'd1, 8'd1, MODE_ADD);
        drain();

        // Randomized operations with random output backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [7:0] rm;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 8'($urandom_range(0, 11));
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            if ((rm == 8'd4 || rm == 8'd5) && $urandom_range(0, 1) == 1) rb = 8'($urandom_range(0, 9));
            if ((rm == 8'd6 || rm == 8'd7) && $urandom_range(0, 1) == 1) ra = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) rm = 8'($urandom_range(12, 255));
            issue(ra, rb, rm);
        end
        @(negedge clk);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
